// File: rtl/fetch_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM states, reset PC, NOP encoding.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: flush clears valid only, data fields keep their last values.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pcplus4_d,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      instr   <= NOP_INSTR;
      pc      <= '0;
      pcplus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instr_d;
      pc      <= pc_d;
      pcplus4 <= pcplus4_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, single-outstanding imem read FSM, IF/ID load.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_misalign and a sticky halt state.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] nnpc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pcplus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  fetch_state_t state;
  logic [31:0]  hold_instr;
  logic         drop;

  logic         accept;
  logic         deliver;
  logic         halted;
  logic         pc_load;
  logic         bad_target;
  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr_d;
  logic [31:0]  next_pc;

  assign imem_req  = (state == S_REQ) & ~rst;
  assign imem_addr = pc;
  assign pcplus4   = pc + 32'd4;
  assign accept    = imem_req & imem_ready;
  assign halted    = (state == S_HALT);

  always_comb begin
    deliver = 1'b0;
    case (state)
      S_WAIT:  deliver = imem_rvalid & ~drop & ~stall;
      S_HOLD:  deliver = ~stall;
      default: deliver = 1'b0;
    endcase
  end

  assign pc_load = (flush | deliver) & ~halted;

`ifdef FETCH_ALIGN_CHECK_EN
  assign bad_target = pc_load & (nnpc[1:0] != 2'b00);
  assign next_pc    = nnpc;
`else
  assign bad_target = 1'b0;
  assign next_pc    = word_align(nnpc);
`endif

  // Any cycle that does not load IF/ID and is not stalled retires the entry as a bubble.
  assign ifid_load    = deliver & ~flush & ~bad_target;
  assign ifid_flush   = ~ifid_load & (flush | ~stall | bad_target | halted);
  assign ifid_instr_d = (state == S_HOLD) ? hold_instr : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_instr <= NOP_INSTR;
      drop       <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else
`ifdef FETCH_ALIGN_CHECK_EN
    if (bad_target) begin
      fetch_misalign <= 1'b1;
      state          <= S_HALT;
      drop           <= 1'b0;
      hold_instr     <= NOP_INSTR;
    end else
`endif
    begin
      if (pc_load) pc <= next_pc;
      if (flush) hold_instr <= NOP_INSTR;
      case (state)
        S_REQ: begin
          if (accept) begin
            state <= S_WAIT;
            drop  <= flush;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (flush | drop | ~stall) begin
              state <= S_REQ;
            end else begin
              hold_instr <= imem_rdata;
              state      <= S_HOLD;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush | ~stall) state <= S_REQ;
        end
        default: state <= state;
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .instr_d   (ifid_instr_d),
    .pc_d      (pc),
    .pcplus4_d (pcplus4),
    .valid     (if_id_valid),
    .instr     (if_id_instr),
    .pc        (if_id_pc),
    .pcplus4   (if_id_pcplus4)
  );

endmodule
